// File: rtl/elevator_pkg.sv
// ============================================================================
// Module      : elevator_pkg
// Description : Shared state encoding, timer width and default timings for
//               the elevator controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package elevator_pkg;

    localparam int          TIMER_W          = 16;
    localparam logic [15:0] DEF_TRAVEL_TICKS = 16'd50;
    localparam logic [15:0] DEF_DOOR_TICKS   = 16'd100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_DOOR = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_MOVE = ST_MOVE,
        S_DOOR = ST_DOOR,
        S_HALT = ST_HALT
    } state_t;

endpackage

`default_nettype wire

// File: rtl/elevator_ctrl_tick_timer.sv
// ============================================================================
// Module      : tick_timer
// Description : Clearable, tick-enabled up counter; clear has priority.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tick_timer
    import elevator_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    output logic [TIMER_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TIMER_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/elevator_ctrl.sv
// ============================================================================
// Module      : elevator_ctrl
// Description : SCAN-scheduled single-car elevator controller. Optional
//               emergency stop (HALT state, estop port) under ELEV_ESTOP_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int          FLOORS       = 4,
    parameter logic [15:0] TRAVEL_TICKS = DEF_TRAVEL_TICKS,
    parameter logic [15:0] DOOR_TICKS   = DEF_DOOR_TICKS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
`ifdef ELEV_ESTOP_EN
    input  logic                      estop,
`endif
    input  logic [FLOORS-1:0]         req,
    output logic [$clog2(FLOORS)-1:0] floor,
    output logic                      dir_up,
    output logic                      moving,
    output logic                      door_open,
    output logic [FLOORS-1:0]         pending
);

    localparam int                FW        = $clog2(FLOORS);
    localparam logic [FLOORS-1:0] FLOOR_LSB = {{(FLOORS-1){1'b0}}, 1'b1};
    localparam logic [FW-1:0]     TOP       = FW'(FLOORS-1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [FW-1:0]        w_floor_nxt;
    logic [FW-1:0]        w_nf;
    logic                 w_dir_nxt;
    logic [FLOORS-1:0]    w_pend_nxt;
    logic [FLOORS-1:0]    w_pend_set;
    logic [FLOORS-1:0]    w_at;
    logic [FLOORS-1:0]    w_below;
    logic [FLOORS-1:0]    w_above;
    logic [FLOORS-1:0]    w_at_nf;
    logic [FLOORS-1:0]    w_below_nf;
    logic [FLOORS-1:0]    w_above_nf;
    logic                 w_up_call;
    logic                 w_dn_call;
    logic                 w_travel_done;
    logic                 w_door_done;
    logic                 w_hold;
    logic                 w_step_clr;
    logic                 w_tmr_clr;
    logic                 w_tmr_en;
    logic                 w_estop;
    logic [TIMER_W-1:0]   w_count;

`ifdef ELEV_ESTOP_EN
    assign w_estop = estop;
`else
    assign w_estop = 1'b0;
`endif

    assign w_pend_set = pending | req;
    assign w_at       = FLOOR_LSB << floor;
    assign w_below    = w_at - FLOOR_LSB;
    assign w_above    = ~(w_below | w_at);
    assign w_nf       = dir_up ? floor + FW'(1) : floor - FW'(1);
    assign w_at_nf    = FLOOR_LSB << w_nf;
    assign w_below_nf = w_at_nf - FLOOR_LSB;
    assign w_above_nf = ~(w_below_nf | w_at_nf);
    assign w_up_call  = |(pending & w_above);
    assign w_dn_call  = |(pending & w_below);

    assign w_travel_done = tick && (w_count == TRAVEL_TICKS - 16'd1);
    assign w_door_done   = tick && (w_count == DOOR_TICKS - 16'd1);
    assign w_hold        = (r_state == S_DOOR) && |(req & w_at);

    always_comb begin
        w_state_nxt = r_state;
        w_floor_nxt = floor;
        w_dir_nxt   = dir_up;
        w_pend_nxt  = w_pend_set;
        w_step_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|(pending & w_at)) begin
                    w_state_nxt = S_DOOR;
                    w_pend_nxt  = w_pend_set & ~w_at;
                    if (floor == '0) begin
                        w_dir_nxt = 1'b1;
                    end else if (floor == TOP) begin
                        w_dir_nxt = 1'b0;
                    end
                end else if (w_up_call && (dir_up || !w_dn_call)) begin
                    w_state_nxt = S_MOVE;
                    w_dir_nxt   = 1'b1;
                end else if (w_dn_call) begin
                    w_state_nxt = S_MOVE;
                    w_dir_nxt   = 1'b0;
                end
            end
            S_MOVE: begin
                if (w_travel_done) begin
                    w_floor_nxt = w_nf;
                    w_step_clr  = 1'b1;
                    if (|(w_pend_set & w_at_nf)) begin
                        w_state_nxt = S_DOOR;
                        w_pend_nxt  = w_pend_set & ~w_at_nf;
                    end else if (!(dir_up ? |(w_pend_set & w_above_nf)
                                          : |(w_pend_set & w_below_nf))) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DOOR: begin
                // A call at the open floor holds the door instead of re-latching.
                if (w_hold) begin
                    w_step_clr = 1'b1;
                    w_pend_nxt = pending | (req & ~w_at);
                end else if (w_door_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef ELEV_ESTOP_EN
            S_HALT: begin
                if (!w_estop) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_estop) begin
            w_state_nxt = S_HALT;
            w_floor_nxt = floor;
            w_dir_nxt   = dir_up;
            w_pend_nxt  = w_pend_set;
            w_step_clr  = 1'b0;
        end
    end

    // HALT entry keeps the count frozen; leaving HALT clears it like any entry.
    assign w_tmr_clr = w_step_clr ||
                       ((w_state_nxt != r_state) && (w_state_nxt != S_HALT));
    assign w_tmr_en  = tick && ((r_state == S_MOVE) || (r_state == S_DOOR));

    tick_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_tmr_clr),
        .en    (w_tmr_en),
        .count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            floor     <= '0;
            dir_up    <= 1'b1;
            pending   <= '0;
            moving    <= 1'b0;
            door_open <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            floor     <= w_floor_nxt;
            dir_up    <= w_dir_nxt;
            pending   <= w_pend_nxt;
            moving    <= (w_state_nxt == S_MOVE);
            door_open <= (w_state_nxt == S_DOOR);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_elevator_ctrl.sv
// ============================================================================
// Module      : tb_elevator_ctrl
// Description : Directed self-checking bench for elevator_ctrl
//               (FLOORS=4, TRAVEL_TICKS=4, DOOR_TICKS=6).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_elevator_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] req;
    logic [1:0] floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic [3:0] pending;
`ifdef ELEV_ESTOP_EN
    logic       estop;
`endif

    int total = 0;
    int bad   = 0;

    elevator_ctrl #(
        .FLOORS       (4),
        .TRAVEL_TICKS (16'd4),
        .DOOR_TICKS   (16'd6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
`ifdef ELEV_ESTOP_EN
        .estop     (estop),
`endif
        .req       (req),
        .floor     (floor),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; tick = 1'b1; req = 4'b0000;
`ifdef ELEV_ESTOP_EN
        estop = 1'b0;
`endif
        step(2);
        total++;
        if ({moving, door_open, dir_up, floor, pending} !== 9'b0_0_1_00_0000) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b",
                     {moving, door_open, dir_up, floor, pending}, 9'b0_0_1_00_0000);
        end
        rst = 1'b0;
        step(2);
        total++;
        if ({moving, door_open, floor} !== 4'b0_0_00) begin
            bad++;
            $display("FAIL reset_release got=%b want=%b", {moving, door_open, floor}, 4'b0);
        end
    endtask

    task automatic test_reset_mid_move;
        req = 4'b1000; step(1); req = 4'b0000;
        step(5);
        total++;
        if ({moving, floor, pending} !== 7'b1_01_1000) begin
            bad++;
            $display("FAIL rmm_pre got=%b want=%b", {moving, floor, pending}, 7'b1_01_1000);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({moving, door_open, floor, pending} !== 8'b0) begin
            bad++;
            $display("FAIL rmm_async got=%b want=%b", {moving, door_open, floor, pending}, 8'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        step(3);
        total++;
        if ({moving, door_open, floor, pending} !== 8'b0) begin
            bad++;
            $display("FAIL rmm_after got=%b want=%b", {moving, door_open, floor, pending}, 8'b0);
        end
    endtask

    task automatic test_single_call;
        logic [3:0] exp;
        req = 4'b0100; step(1); req = 4'b0000;
        total++;
        if ({moving, pending} !== 5'b0_0100) begin
            bad++;
            $display("FAIL single_latch got=%b want=%b", {moving, pending}, 5'b0_0100);
        end
        for (int i = 0; i < 8; i++) begin
            step(1);
            exp = {1'b1, 1'b0, (i < 4) ? 2'd0 : 2'd1};
            total++;
            if ({moving, door_open, floor} !== exp) begin
                bad++;
                $display("FAIL single_move[%0d] got=%b want=%b", i, {moving, door_open, floor}, exp);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(1);
            total++;
            if ({moving, door_open, floor, pending} !== 8'b0_1_10_0000) begin
                bad++;
                $display("FAIL single_door[%0d] got=%b want=%b", i,
                         {moving, door_open, floor, pending}, 8'b0_1_10_0000);
            end
        end
        step(1);
        total++;
        if ({moving, door_open, floor} !== 4'b0_0_10) begin
            bad++;
            $display("FAIL single_idle got=%b want=%b", {moving, door_open, floor}, 4'b0_0_10);
        end
    endtask

    task automatic test_scan;
        logic [1:0] tr [8];
        logic [1:0] exp_tr [6];
        logic [1:0] last;
        int         n;
        exp_tr = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        rst = 1'b1; step(1); rst = 1'b0;
        req = 4'b1000; step(1); req = 4'b0000;
        step(5);
        total++;
        if ({moving, dir_up, floor} !== 4'b1_1_01) begin
            bad++;
            $display("FAIL scan_pre got=%b want=%b", {moving, dir_up, floor}, 4'b1_1_01);
        end
        req = 4'b1001; step(1); req = 4'b0000;
        total++;
        if (pending !== 4'b1001) begin
            bad++;
            $display("FAIL scan_latch got=%b want=%b", pending, 4'b1001);
        end
        last = floor; tr[0] = floor; n = 1;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (floor !== last) begin
                if (n < 8) tr[n] = floor;
                n++;
                last = floor;
            end
        end
        total++;
        if (n != 6) begin
            bad++;
            $display("FAIL scan_len got=%0d want=%0d", n, 6);
        end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (tr[k] !== exp_tr[k]) begin
                bad++;
                $display("FAIL scan_trace[%0d] got=%0d want=%0d", k, tr[k], exp_tr[k]);
            end
        end
        total++;
        if ({moving, door_open, floor, pending} !== 8'b0) begin
            bad++;
            $display("FAIL scan_end got=%b want=%b", {moving, door_open, floor, pending}, 8'b0);
        end
    endtask

    task automatic test_door_hold;
        req = 4'b0100; step(1); req = 4'b0000;
        step(9);
        total++;
        if ({moving, door_open, floor} !== 4'b0_1_10) begin
            bad++;
            $display("FAIL hold_entry got=%b want=%b", {moving, door_open, floor}, 4'b0_1_10);
        end
        step(4);
        req = 4'b0100; step(1); req = 4'b0000;
        total++;
        if ({door_open, pending} !== 5'b1_0000) begin
            bad++;
            $display("FAIL hold_req got=%b want=%b", {door_open, pending}, 5'b1_0000);
        end
        for (int i = 0; i < 5; i++) begin
            step(1);
            total++;
            if (door_open !== 1'b1) begin
                bad++;
                $display("FAIL hold_open[%0d] got=%b want=%b", i, door_open, 1'b1);
            end
        end
        step(1);
        total++;
        if ({moving, door_open} !== 2'b00) begin
            bad++;
            $display("FAIL hold_close got=%b want=%b", {moving, door_open}, 2'b00);
        end
    endtask

    task automatic test_tick_freeze;
        req = 4'b1000; step(1); req = 4'b0000;
        step(3);
        tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req = (i == 2) ? 4'b0010 : 4'b0000;
            step(1);
            total++;
            if ({moving, door_open, floor} !== 4'b1_0_10) begin
                bad++;
                $display("FAIL freeze[%0d] got=%b want=%b", i, {moving, door_open, floor}, 4'b1_0_10);
            end
        end
        req = 4'b0000;
        total++;
        if (pending !== 4'b1010) begin
            bad++;
            $display("FAIL freeze_latch got=%b want=%b", pending, 4'b1010);
        end
        tick = 1'b1;
        step(1);
        total++;
        if ({moving, floor} !== 3'b1_10) begin
            bad++;
            $display("FAIL freeze_resume got=%b want=%b", {moving, floor}, 3'b1_10);
        end
        step(1);
        total++;
        if ({door_open, floor, pending} !== 7'b1_11_0010) begin
            bad++;
            $display("FAIL freeze_arrive got=%b want=%b", {door_open, floor, pending}, 7'b1_11_0010);
        end
        step(21);
        total++;
        if ({moving, door_open, floor, pending} !== 8'b0_0_01_0000) begin
            bad++;
            $display("FAIL freeze_end got=%b want=%b",
                     {moving, door_open, floor, pending}, 8'b0_0_01_0000);
        end
    endtask

    task automatic test_back_to_back;
        req = 4'b0001;
        step(6);
        total++;
        if ({door_open, floor, pending} !== 7'b1_00_0000) begin
            bad++;
            $display("FAIL clrwins got=%b want=%b", {door_open, floor, pending}, 7'b1_00_0000);
        end
        req = 4'b0000;
        step(6);
        total++;
        if ({moving, door_open, dir_up} !== 3'b0_0_0) begin
            bad++;
            $display("FAIL b2b_idle got=%b want=%b", {moving, door_open, dir_up}, 3'b000);
        end
        req = 4'b0001; step(1); req = 4'b0000;
        step(1);
        total++;
        if ({moving, door_open, dir_up, floor, pending} !== 9'b0_1_1_00_0000) begin
            bad++;
            $display("FAIL own_floor got=%b want=%b",
                     {moving, door_open, dir_up, floor, pending}, 9'b0_1_1_00_0000);
        end
        step(6);
        total++;
        if (door_open !== 1'b0) begin
            bad++;
            $display("FAIL own_close got=%b want=%b", door_open, 1'b0);
        end
    endtask

`ifdef ELEV_ESTOP_EN
    task automatic test_estop;
        req = 4'b0100; step(1); req = 4'b0000;
        step(5);
        estop = 1'b1;
        step(1);
        total++;
        if ({moving, door_open, floor, pending} !== 8'b0_0_01_0100) begin
            bad++;
            $display("FAIL estop_halt got=%b want=%b",
                     {moving, door_open, floor, pending}, 8'b0_0_01_0100);
        end
        step(2);
        total++;
        if ({moving, door_open, floor, pending} !== 8'b0_0_01_0100) begin
            bad++;
            $display("FAIL estop_hold got=%b want=%b",
                     {moving, door_open, floor, pending}, 8'b0_0_01_0100);
        end
        estop = 1'b0;
        step(1);
        total++;
        if ({moving, floor} !== 3'b0_01) begin
            bad++;
            $display("FAIL estop_idle got=%b want=%b", {moving, floor}, 3'b0_01);
        end
        step(1);
        total++;
        if (moving !== 1'b1) begin
            bad++;
            $display("FAIL estop_resume got=%b want=%b", moving, 1'b1);
        end
        step(4);
        total++;
        if ({door_open, floor, pending} !== 7'b1_10_0000) begin
            bad++;
            $display("FAIL estop_serve got=%b want=%b", {door_open, floor, pending}, 7'b1_10_0000);
        end
        step(6);
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_move();
        test_single_call();
        test_scan();
        test_door_hold();
        test_tick_freeze();
        test_back_to_back();
`ifdef ELEV_ESTOP_EN
        test_estop();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter FLOORS, default 4, number of served floors (2..16).
REQ-002 Parameter TRAVEL_TICKS, default 16'd50, timebase ticks per one-floor move.
REQ-003 Parameter DOOR_TICKS, default 16'd100, timebase ticks door stays open.
REQ-004 Port clk  input  1  single system clock; all state changes on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port tick  input  1  timebase enable; timers advance only on cycles with tick=1.
REQ-007 Port req  input  FLOORS  floor call lines, one bit per floor, sampled each cycle.
REQ-008 Port floor  output  $clog2(FLOORS)  current floor number.
REQ-009 Port dir_up  output  1  scan direction, 1=up, 0=down.
REQ-010 Port moving  output  1  high in MOVE state.
REQ-011 Port door_open  output  1  high in DOOR state.
REQ-012 Port pending  output  FLOORS  latched outstanding calls.

Function
REQ-013 SHALL implement states IDLE, MOVE, DOOR (plus HALT under REQ-027); all outputs registered.
REQ-014 pending[i] SHALL set on any cycle req[i]=1 and clear only on entry to DOOR at floor i; set and clear of same bit in one cycle -> clear wins.
REQ-015 Internal 16-bit timer SHALL clear on every state entry and increment by 1 on each tick in MOVE or DOOR; no wrap occurs since expiry resets it.
REQ-016 IDLE: pending[floor] set -> DOOR next cycle; else call above (checked first if dir_up=1, else below first) -> MOVE with dir_up set toward it; none -> stay IDLE.
REQ-017 MOVE: on tick with timer == TRAVEL_TICKS-1, floor SHALL step by +1 (dir_up) or -1 in the same edge, then: pending at new floor -> DOOR; further calls ahead -> stay MOVE (timer cleared); else -> IDLE.
REQ-018 DOOR: on tick with timer == DOOR_TICKS-1 -> IDLE; req at current floor while in DOOR SHALL clear timer (door held), pending bit not set.
REQ-019 Scheduling SHALL be SCAN: direction reverses only in IDLE when no call exists ahead.
REQ-020 floor SHALL never leave 0..FLOORS-1; at floor 0 dir_up forced 1, at FLOORS-1 forced 0 on IDLE exit.
REQ-021 Calls arriving during MOVE for a floor already passed SHALL remain pending until served on a later scan.
REQ-022 tick=0 SHALL freeze timer and state in MOVE/DOOR; req still latches.

Reset
REQ-023 rst=1 SHALL asynchronously force state IDLE, floor 0, dir_up 1, moving 0, door_open 0, pending 0, timer 0.
REQ-024 Reset mid-MOVE or mid-DOOR SHALL discard all calls; no partial floor step retained.

Configuration
REQ-025 Macro ELEV_ESTOP_EN SHALL gate an emergency-stop feature.
REQ-026 Without ELEV_ESTOP_EN: no estop port, no HALT state.
REQ-027 With ELEV_ESTOP_EN: input estop (1 bit); estop=1 from any state -> HALT next cycle, moving 0, door_open 0, timer frozen, floor unchanged, pending retained; estop=0 in HALT -> IDLE, partial travel discarded.

Structure
REQ-028 Package elevator_pkg SHALL hold state encoding constants, default TRAVEL_TICKS/DOOR_TICKS, timer width (16).
REQ-029 Sub-module tick_timer (16-bit clearable tick-enabled counter, ports clk, rst, clr, en, count) SHALL be instantiated once.

Verification (FLOORS=4, TRAVEL_TICKS=4, DOOR_TICKS=6, tick=1 unless stated)
REQ-030 Reset mid-MOVE with pending=4'b1000 -> floor 0, pending 0, IDLE within same cycle as rst rise.
REQ-031 From IDLE floor 0, pulse req[2] -> moving 1 for 8 cycles, floor 0->1->2, door_open 1 for 6 cycles, pending[2] cleared on door entry, then IDLE.
REQ-032 At floor 1 moving up, calls req[0] and req[3] -> serves 3 first, then reverses, serves 0; floor trace 1,2,3,2,1,0.
REQ-033 In DOOR at floor 2, req[2] at timer=4 -> door stays open 6 more ticks.
REQ-034 tick=0 for 10 cycles during MOVE -> floor and timer unchanged, then resumes exact remaining count.
REQ-035 ELEV_ESTOP_EN build: estop during MOVE at floor 1 -> HALT, outputs 0, pending kept; release -> IDLE at floor 1 then resumes serving.
